pipeline_stall_sequencer: RTL and testbench

// - Sequences fetch/decode of the 20-bit pipeline: decodes ins_pm[19:15] from program memory, schedules

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/pipeline_stall_sequencer_stall_counter.sv | 26 ++
 rtl/pipeline_stall_sequencer.sv | 110 +++++++++++
 tb/tb_pipeline_stall_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode constants and sequencer state encodings for the 20-bit pipeline control path.
package pipe_ctrl_pkg;

  localparam logic [4:0] OPC_LOAD = 5'b10100;
  localparam logic [4:0] OPC_HALT = 5'b10001;
  localparam logic [2:0] JUMP_PFX = 3'b111;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_LOAD_WAIT = 3'd1,
    ST_JFLUSH    = 3'd2,
    ST_HALT      = 3'd3
  } state_t;

endpackage

// File: rtl/pipeline_stall_sequencer_stall_counter.sv
// Down-counter for bubble/flush windows: loadable, decrements to zero and holds there.
module stall_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// Fetch/decode sequencer: decodes hazard opcodes from program memory and drives PC/IR enables,
// bubble/flush injection, and the stall indications for the IF/ID stage.
module pipeline_stall_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int JUMP_FLUSH   = 2,
  parameter int CNT_W        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] ins_pm,
  input  logic        mem_ready,
  input  logic        resume,
  output logic        pc_en,
  output logic        ir_en,
  output logic        bubble,
  output logic        flush,
  output logic        stall,
  output logic        stall_pm,
  output logic        halted,
  output logic [2:0]  state_dbg
);

  state_t           state, state_nxt;
  logic             in_run;
  logic             jump_op, load_op, halt_op;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val, cnt;
  logic             unused_ins;

  // Squashed or held words must not re-trigger, so decode is gated by RUN.
  assign in_run  = (state == ST_RUN);
  assign jump_op = in_run && (ins_pm[19:17] == JUMP_PFX);
  assign load_op = in_run && (ins_pm[19:15] == OPC_LOAD);
  assign halt_op = in_run && (ins_pm[19:15] == OPC_HALT);
  assign unused_ins = ^{ins_pm[14:0], cnt};

  stall_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      stall_pm <= 1'b0;
    end else begin
      state    <= state_nxt;
      stall_pm <= stall;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    pc_en     = 1'b1;
    ir_en     = 1'b1;
    bubble    = 1'b0;
    flush     = 1'b0;
    halted    = 1'b0;
    case (state)
      ST_RUN: begin
        if (halt_op) begin
          state_nxt = ST_HALT;
        end else if (jump_op) begin
          state_nxt = ST_JFLUSH;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(JUMP_FLUSH - 1);
        end else if (load_op) begin
          state_nxt = ST_LOAD_WAIT;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(LOAD_BUBBLES - 1);
        end
      end
      ST_LOAD_WAIT: begin
        pc_en   = 1'b0;
        ir_en   = 1'b0;
        bubble  = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_zero && mem_ready) state_nxt = ST_RUN;
      end
      ST_JFLUSH: begin
        flush   = 1'b1;
        bubble  = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_zero) state_nxt = ST_RUN;
      end
      ST_HALT: begin
        pc_en  = 1'b0;
        ir_en  = 1'b0;
        bubble = 1'b1;
        halted = 1'b1;
        if (resume) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  assign stall     = !in_run || jump_op || load_op || halt_op;
  assign state_dbg = state;

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Scoreboard bench: a cycle-level reference model predicts every output vector; a monitor compares.
module tb_pipeline_stall_sequencer;

  localparam int LB = 1;
  localparam int JF = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] ins_pm = '0;
  logic        mem_ready = 1'b0;
  logic        resume = 1'b0;
  logic        pc_en, ir_en, bubble, flush, stall, stall_pm, halted;
  logic [2:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [9:0] exp_q[$];

  // Reference model: windows of remaining bubble/flush cycles plus hold flags.
  bit m_halted = 1'b0;
  bit m_load_active = 1'b0;
  int m_load_left = 0;
  int m_flush_left = 0;
  bit m_prev_stall = 1'b0;

  localparam logic [19:0] NOP  = 20'h0_1234;
  localparam logic [19:0] LOAD = 20'hA_0000;
  localparam logic [19:0] JMP  = 20'hE_0000;
  localparam logic [19:0] HALT = 20'h8_8000;

  pipeline_stall_sequencer #(.LOAD_BUBBLES(LB), .JUMP_FLUSH(JF), .CNT_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .ins_pm    (ins_pm),
    .mem_ready (mem_ready),
    .resume    (resume),
    .pc_en     (pc_en),
    .ir_en     (ir_en),
    .bubble    (bubble),
    .flush     (flush),
    .stall     (stall),
    .stall_pm  (stall_pm),
    .halted    (halted),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic [19:0] ins, input logic mr, input logic res, input logic rst);
    logic [9:0] e;
    logic hz_j, hz_l, hz_h, hz;
    @(posedge clk);
    #1;
    reset = rst;
    ins_pm = ins;
    mem_ready = mr;
    resume = res;
    hz_j = (ins[19:17] == 3'b111);
    hz_l = (ins[19:15] == 5'b10100);
    hz_h = (ins[19:15] == 5'b10001);
    hz = hz_j | hz_l | hz_h;
    if (rst) begin
      e = {1'b1, 1'b1, 1'b0, 1'b0, hz, 1'b0, 1'b0, 3'd0};
      m_halted = 1'b0;
      m_load_active = 1'b0;
      m_load_left = 0;
      m_flush_left = 0;
      m_prev_stall = 1'b0;
    end else if (m_halted) begin
      e = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, m_prev_stall, 1'b1, 3'd3};
      m_prev_stall = 1'b1;
      if (res) m_halted = 1'b0;
    end else if (m_load_active) begin
      e = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, m_prev_stall, 1'b0, 3'd1};
      m_prev_stall = 1'b1;
      if (m_load_left > 0) m_load_left--;
      if (m_load_left == 0 && mr) m_load_active = 1'b0;
    end else if (m_flush_left > 0) begin
      e = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, m_prev_stall, 1'b0, 3'd2};
      m_prev_stall = 1'b1;
      m_flush_left--;
    end else begin
      e = {1'b1, 1'b1, 1'b0, 1'b0, hz, m_prev_stall, 1'b0, 3'd0};
      m_prev_stall = hz;
      if (hz_h) m_halted = 1'b1;
      else if (hz_j) m_flush_left = JF;
      else if (hz_l) begin
        m_load_active = 1'b1;
        m_load_left = LB;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: sample mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [9:0] exp_v, act_v;
      exp_v = exp_q.pop_front();
      act_v = {pc_en, ir_en, bubble, flush, stall, stall_pm, halted, state_dbg};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL cyc%0d outputs {pc,ir,bub,fl,st,stpm,hlt,dbg}: got %b required %b",
                 cyc, act_v, exp_v);
      end
      cyc++;
    end
  end

  initial begin
    logic [19:0] w;
    int r;
    // Reset and idle run
    step(NOP, 1'b1, 1'b0, 1'b1);
    step(NOP, 1'b1, 1'b0, 1'b1);
    step(NOP, 1'b1, 1'b0, 1'b0);
    step(NOP, 1'b1, 1'b0, 1'b0);
    // Load with memory ready
    step(LOAD | 20'h00123, 1'b1, 1'b0, 1'b0);
    step(NOP, 1'b1, 1'b0, 1'b0);
    step(NOP, 1'b1, 1'b0, 1'b0);
    // Load with memory late by three cycles
    step(LOAD, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(NOP, 1'b0, 1'b0, 1'b0);
    step(NOP, 1'b1, 1'b0, 1'b0);
    step(NOP, 1'b1, 1'b0, 1'b0);
    // Jump followed by jump words that must be squashed
    step(JMP, 1'b0, 1'b0, 1'b0);
    step(JMP | 20'h1ABCD, 1'b0, 1'b0, 1'b0);
    step(JMP, 1'b0, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b0);
    // Halt held, then resumed; resume in RUN is ignored
    step(HALT, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(LOAD, 1'b1, 1'b0, 1'b0);
    step(NOP, 1'b1, 1'b1, 1'b0);
    step(NOP, 1'b1, 1'b1, 1'b0);
    step(NOP, 1'b1, 1'b0, 1'b0);
    // Reset mid-cycle during HALT and during JFLUSH
    step(HALT, 1'b1, 1'b0, 1'b0);
    step(NOP, 1'b1, 1'b0, 1'b0);
    step(JMP, 1'b1, 1'b0, 1'b1);
    step(NOP, 1'b1, 1'b0, 1'b0);
    step(JMP, 1'b1, 1'b0, 1'b0);
    step(NOP, 1'b1, 1'b0, 1'b1);
    step(NOP, 1'b1, 1'b0, 1'b0);
    step(NOP, 1'b1, 1'b0, 1'b0);
    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      w = 20'($urandom);
      r = $urandom_range(0, 99);
      if (r < 8) w[19:15] = 5'b10100;
      else if (r < 16) w[19:17] = 3'b111;
      else if (r < 20) w[19:15] = 5'b10001;
      else if (w[19:17] == 3'b111 || w[19:15] == 5'b10100 || w[19:15] == 5'b10001) w[19] = 1'b0;
      step(w, ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 199) == 0));
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard drain: got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
